// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter_if
// Description : Writeback request, regfile write and hazard-probe bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wr_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] chk_addr;
  logic          chk_hit;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output chk_addr,
    input  a_ready, b_ready,
    input  we3, wa3, wd3,
    input  chk_hit
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  chk_addr,
    output a_ready, b_ready,
    output we3, wa3, wd3,
    output chk_hit
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Round-robin sharing of the regfile write port between the ALU
//               (A) and load unit (B), each behind a 1-entry holding slot.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int ZERO_DROP = 1
) (
  input  wire logic            clk,
  input  wire logic            reset,
  regfile_wr_arbiter_if.slave  bus
);

  localparam logic [0:0] C_GRANT_A = 1'b0;
  localparam logic [0:0] C_GRANT_B = 1'b1;
  localparam logic       C_ZDROP   = (ZERO_DROP != 0);

  logic          a_full_q, a_full_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [DW-1:0] a_data_q, a_data_d;
  logic          b_full_q, b_full_d;
  logic [AW-1:0] b_addr_q, b_addr_d;
  logic [DW-1:0] b_data_q, b_data_d;
  logic [0:0]    last_grant_q, last_grant_d;
  logic          we3_q, we3_d;
  logic [AW-1:0] wa3_q, wa3_d;
  logic [DW-1:0] wd3_q, wd3_d;

  logic a_zero, b_zero;
  logic a_elig, b_elig;
  logic a_drop, b_drop;
  logic grant_a, grant_b;
  logic a_acc, b_acc;
  logic chk_en;

  // Address-0 slots are retired without ever competing for the port.
  assign a_zero  = C_ZDROP && (a_addr_q == '0);
  assign b_zero  = C_ZDROP && (b_addr_q == '0);
  assign a_elig  = a_full_q & ~a_zero;
  assign b_elig  = b_full_q & ~b_zero;
  assign a_drop  = a_full_q &  a_zero;
  assign b_drop  = b_full_q &  b_zero;

  assign grant_a = a_elig & (~b_elig | (last_grant_q == C_GRANT_B));
  assign grant_b = b_elig & ~grant_a;

  assign bus.a_ready = ~a_full_q | grant_a;
  assign bus.b_ready = ~b_full_q | grant_b;
  assign a_acc       = bus.a_valid & bus.a_ready;
  assign b_acc       = bus.b_valid & bus.b_ready;

  always_comb begin
    a_full_d = a_full_q;
    a_addr_d = a_addr_q;
    a_data_d = a_data_q;
    if (grant_a || a_drop) begin
      a_full_d = 1'b0;
    end
    if (a_acc) begin
      a_full_d = 1'b1;
      a_addr_d = bus.a_addr;
      a_data_d = bus.a_data;
    end
  end

  always_comb begin
    b_full_d = b_full_q;
    b_addr_d = b_addr_q;
    b_data_d = b_data_q;
    if (grant_b || b_drop) begin
      b_full_d = 1'b0;
    end
    if (b_acc) begin
      b_full_d = 1'b1;
      b_addr_d = bus.b_addr;
      b_data_d = bus.b_data;
    end
  end

  // Write port holds its last address/data between grants.
  always_comb begin
    we3_d        = grant_a | grant_b;
    wa3_d        = wa3_q;
    wd3_d        = wd3_q;
    last_grant_d = last_grant_q;
    if (grant_a) begin
      wa3_d        = a_addr_q;
      wd3_d        = a_data_q;
      last_grant_d = C_GRANT_A;
    end else if (grant_b) begin
      wa3_d        = b_addr_q;
      wd3_d        = b_data_q;
      last_grant_d = C_GRANT_B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_full_q     <= 1'b0;
      a_addr_q     <= '0;
      a_data_q     <= '0;
      b_full_q     <= 1'b0;
      b_addr_q     <= '0;
      b_data_q     <= '0;
      last_grant_q <= C_GRANT_B;
      we3_q        <= 1'b0;
      wa3_q        <= '0;
      wd3_q        <= '0;
    end else begin
      a_full_q     <= a_full_d;
      a_addr_q     <= a_addr_d;
      a_data_q     <= a_data_d;
      b_full_q     <= b_full_d;
      b_addr_q     <= b_addr_d;
      b_data_q     <= b_data_d;
      last_grant_q <= last_grant_d;
      we3_q        <= we3_d;
      wa3_q        <= wa3_d;
      wd3_q        <= wd3_d;
    end
  end

  assign bus.we3 = we3_q;
  assign bus.wa3 = wa3_q;
  assign bus.wd3 = wd3_q;

  // x0 is never a hazard when its writes are discarded.
  assign chk_en      = (bus.chk_addr != '0) || !C_ZDROP;
  assign bus.chk_hit = chk_en &
                       ((a_full_q && (a_addr_q == bus.chk_addr)) ||
                        (b_full_q && (b_addr_q == bus.chk_addr)) ||
                        (we3_q    && (wa3_q    == bus.chk_addr)));

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Directed and randomized self-checking bench with a
//               transaction-level reference model and a shadow regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam bit ZD = 1'b1;

  typedef struct {
    bit             full;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } slot_t;

  logic clk;
  logic reset;
  bit   rf_clr;
  int   n_tests;
  int   n_fail;

  logic [DW-1:0] rf [32];

  slot_t         m_a, m_b;
  bit            m_turn_a;
  bit            m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rf [32];

  regfile_wr_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  regfile_wr_arbiter #(.DW(DW), .AW(AW), .ZERO_DROP(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow regfile driven from the DUT write port.
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.we3 === 1'b1) begin
      rf[bus.wa3] <= bus.wd3;
    end
  end

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return (a == 0) ? '0 : rf[a];
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a      = '{0, '0, '0};
    m_b      = '{0, '0, '0};
    m_turn_a = 1'b1;
    m_we     = 1'b0;
    m_wa     = '0;
    m_wd     = '0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input bit rst,
                      input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic [AW-1:0] ca,
                      output bit acc_a, output bit acc_b);
    bit            a_cand, b_cand, exp_ra, exp_rb, exp_hit;
    int            win;
    logic [AW-1:0] pend[$];
    @(negedge clk);
    reset        = rst;
    bus.a_valid  = av;  bus.a_addr = aa;  bus.a_data = ad;
    bus.b_valid  = bv;  bus.b_addr = ba;  bus.b_data = bd;
    bus.chk_addr = ca;
    #1;
    a_cand = m_a.full && !(ZD && m_a.addr == 0);
    b_cand = m_b.full && !(ZD && m_b.addr == 0);
    if (a_cand && b_cand) win = m_turn_a ? 1 : 2;
    else if (a_cand)      win = 1;
    else if (b_cand)      win = 2;
    else                  win = 0;
    exp_ra = !m_a.full || (win == 1);
    exp_rb = !m_b.full || (win == 2);
    if (m_a.full) pend.push_back(m_a.addr);
    if (m_b.full) pend.push_back(m_b.addr);
    if (m_we)     pend.push_back(m_wa);
    exp_hit = 1'b0;
    foreach (pend[i]) if (pend[i] == ca) exp_hit = 1'b1;
    if (ZD && ca == 0) exp_hit = 1'b0;

    chk("a_ready", {31'b0, bus.a_ready}, {31'b0, exp_ra});
    chk("b_ready", {31'b0, bus.b_ready}, {31'b0, exp_rb});
    chk("chk_hit", {31'b0, bus.chk_hit}, {31'b0, exp_hit});
    chk("we3",     {31'b0, bus.we3},     {31'b0, m_we});
    chk("wa3",     {27'b0, bus.wa3},     {27'b0, m_wa});
    chk("wd3",     bus.wd3,              m_wd);

    if (m_we) m_rf[m_wa] = m_wd;
    acc_a = !rst && av && exp_ra;
    acc_b = !rst && bv && exp_rb;
    if (rst) begin
      model_reset();
    end else begin
      m_we = (win != 0);
      if (win == 1) begin m_wa = m_a.addr; m_wd = m_a.data; m_turn_a = 1'b0; end
      if (win == 2) begin m_wa = m_b.addr; m_wd = m_b.data; m_turn_a = 1'b1; end
      if (m_a.full && (win == 1 || (ZD && m_a.addr == 0))) m_a.full = 0;
      if (m_b.full && (win == 2 || (ZD && m_b.addr == 0))) m_b.full = 0;
      if (acc_a) m_a = '{1, aa, ad};
      if (acc_b) m_b = '{1, ba, bd};
    end
  endtask

  task automatic idle(input logic [AW-1:0] ca);
    bit xa, xb;
    step(0, 0, '0, '0, 0, '0, '0, ca, xa, xb);
  endtask

  initial begin
    bit            ka, kb;
    bit            av, bv;
    logic [AW-1:0] aa, ba, ca;
    logic [DW-1:0] ad, bd;
    logic [AW-1:0] exp_wa;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    model_reset();

    // Bring the design to a known state before any comparison.
    rf_clr = 1'b1;
    reset  = 1'b1;
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'h5;
    bus.b_valid = 1'b1; bus.b_addr = 5'd2; bus.b_data = 32'h6;
    bus.chk_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rf_clr = 1'b0;

    // T1: reset held with both requesters valid
    step(1, 1, 5'd1, 32'h5, 1, 5'd2, 32'h6, '0, ka, kb);
    step(1, 1, 5'd1, 32'h5, 1, 5'd2, 32'h6, '0, ka, kb);
    chk("t1_we3",     {31'b0, bus.we3}, 32'd0);
    chk("t1_wd3",     bus.wd3, 32'd0);
    chk("t1_a_ready", {31'b0, bus.a_ready}, 32'd1);
    chk("t1_b_ready", {31'b0, bus.b_ready}, 32'd1);
    chk("t1_chk_hit", {31'b0, bus.chk_hit}, 32'd0);

    // T2: single write, best-case latency
    step(0, 1, 5'd1, 32'd2, 0, '0, '0, '0, ka, kb);
    idle('0);
    idle('0);
    chk("t2_we3", {31'b0, bus.we3}, 32'd1);
    chk("t2_wa3", {27'b0, bus.wa3}, 32'd1);
    chk("t2_wd3", bus.wd3, 32'd2);
    idle('0);
    chk("t2_rf1", rd(5'd1), 32'd2);

    // T3: continuous contention after reset
    step(1, 0, '0, '0, 0, '0, '0, '0, ka, kb);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 5'd3, 32'd7, 1, 5'd4, 32'd9, '0, ka, kb);
      if (i >= 1) chk("t3_a_ready", {31'b0, bus.a_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i >= 2) begin
        exp_wa = (i % 2 == 0) ? 5'd3 : 5'd4;
        chk("t3_we3", {31'b0, bus.we3}, 32'd1);
        chk("t3_wa3", {27'b0, bus.wa3}, {27'b0, exp_wa});
      end
    end
    repeat (4) idle('0);

    // T4: write to x0 is absorbed
    step(0, 1, 5'd0, 32'hFFFF_FFFF, 0, '0, '0, '0, ka, kb);
    for (int i = 0; i < 3; i++) begin
      idle('0);
      chk("t4_we3",     {31'b0, bus.we3}, 32'd0);
      chk("t4_chk_hit", {31'b0, bus.chk_hit}, 32'd0);
    end
    chk("t4_rf0", rd(5'd0), 32'd0);

    // T5: B pending on r5 while A is granted first
    step(1, 0, '0, '0, 0, '0, '0, 5'd5, ka, kb);
    step(0, 1, 5'd6, 32'd11, 1, 5'd5, 32'd22, 5'd5, ka, kb);
    for (int i = 0; i < 4; i++) begin
      idle(5'd5);
      chk("t5_chk_hit", {31'b0, bus.chk_hit}, (i < 3) ? 32'd1 : 32'd0);
    end

    // T6: reset with both slots full
    step(0, 1, 5'd7, 32'd33, 1, 5'd8, 32'd44, '0, ka, kb);
    step(1, 0, '0, '0, 0, '0, '0, 5'd7, ka, kb);
    idle(5'd7);
    chk("t6_we3",     {31'b0, bus.we3}, 32'd0);
    chk("t6_a_ready", {31'b0, bus.a_ready}, 32'd1);
    chk("t6_b_ready", {31'b0, bus.b_ready}, 32'd1);
    chk("t6_chk_hit", {31'b0, bus.chk_hit}, 32'd0);
    repeat (3) idle('0);
    chk("t6_rf7", rd(5'd7), 32'd0);
    chk("t6_rf8", rd(5'd8), 32'd0);

    // Randomized traffic; an unaccepted request is held stable.
    av = 0; bv = 0; aa = '0; ba = '0; ad = '0; bd = '0;
    ka = 1; kb = 1;
    for (int i = 0; i < 400; i++) begin
      if (!av || ka) begin
        av = ($urandom_range(0, 9) < 6);
        aa = 5'($urandom_range(0, 7));
        ad = $urandom;
      end
      if (!bv || kb) begin
        bv = ($urandom_range(0, 9) < 6);
        ba = 5'($urandom_range(0, 7));
        bd = $urandom;
      end
      ca = 5'($urandom_range(0, 7));
      step(($urandom_range(0, 39) == 0), av, aa, ad, bv, ba, bd, ca, ka, kb);
    end
    repeat (4) idle('0);
    for (int r = 0; r < 32; r++) chk("rf_final", rd(5'(r)), m_rf[r]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
